button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Upstream conditioning stage for the board push-buttons that drive the LED counter logic.
- Synchronises a raw, bouncy button input to clk and filters it with a counter-based FSM.
- Emits a clean level plus single-cycle press/release strobes, which downstream counters use as enable/step/clear.
- Optional long-press strobe for a secondary function.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a change (20 ms at 50 MHz); legal range 1 .. 2^CNT_W-1.
- LONG_CYCLES, 50_000_000, held-cycles before long-press strobe (1 s at 50 MHz); only used with LONG_PRESS_EN.
- CNT_W, 26, width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_in  input  1  raw button, active-high, asynchronous to clk
- btn_level  output  1  debounced level, 1 = pressed
- btn_press  output  1  one-cycle strobe on accepted press
- btn_release  output  1  one-cycle strobe on accepted release
- btn_long  output  1  one-cycle strobe on long press (0 without LONG_PRESS_EN)

Behaviour:
- Reset: rst_n low asynchronously forces FSM=IDLE, both synchroniser flops=0, counters=0 and all outputs=0. This includes reset mid-count. Release of rst_n is sampled synchronously.
- Synchroniser: two-flop chain on btn_in; the FSM sees only stage 2 (sync).
- All outputs are registered; no combinational path from btn_in to any output.
- IDLE (btn_level=0): if sync=1, go to CHECK_PRESS with cnt=0.
- CHECK_PRESS:
  - sync=0: return to IDLE, no strobe (bounce rejected).
  - sync=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, btn_level<=1, btn_press<=1 for exactly one cycle.
  - Otherwise: cnt<=cnt+1.
- PRESSED (btn_level=1): if sync=0, go to CHECK_RELEASE with cnt=0.
- CHECK_RELEASE (btn_level stays 1):
  - sync=1: return to PRESSED, no strobe.
  - sync=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, btn_level<=0, btn_release<=1 for one cycle.
  - Otherwise: cnt<=cnt+1.
- Latency: btn_in first sampled 1 at edge k → FSM enters CHECK_PRESS at edge k+2 → btn_press and btn_level high from edge k+2+DEBOUNCE_CYCLES. Release latency is identical.
- Each glitch shorter than DEBOUNCE_CYCLES restarts the count from 0; an accepted change requires an unbroken run.
- btn_press and btn_release are never high in the same cycle. Each accepted transition produces exactly one strobe.
- DEBOUNCE_CYCLES=1: a change is accepted after a single stable cycle in CHECK_*.
- Counters never wrap: cnt is cleared on every CHECK_* entry and stops at the compare value.

Optional Feature:
- Macro: LONG_PRESS_EN.
- When defined:
  - A hold counter runs while the FSM is in PRESSED or CHECK_RELEASE.
  - When the hold counter equals LONG_CYCLES-1, btn_long<=1 for one cycle. The counter then saturates, so there is at most one btn_long per press.
  - The hold counter clears on entry to IDLE and on reset.
  - A bounce back from CHECK_RELEASE to PRESSED does not clear it.
- When undefined: no hold counter is built; btn_long is tied to 0 and the port remains present.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, CNT_W=8):
- Reset: rst_n=0 asynchronously mid-CHECK_PRESS → all outputs 0 immediately; after release, btn_in held 0 → outputs stay 0.
- Clean press: btn_in 0→1 first sampled at edge k, held → btn_press=1 only in cycle starting at edge k+6; btn_level=1 from k+6 onward.
- Bounce reject: btn_in pattern 1,1,1,0 repeated 5 times → no btn_press; btn_level stays 0.
- Clean release after press: btn_in 1→0 first sampled at edge m, held → btn_release=1 only at edge m+6; btn_level=0 from m+6.
- Release glitch: while pressed, btn_in low for 2 cycles then high → btn_level stays 1; no btn_release; no second btn_press.
- LONG_PRESS_EN defined: hold btn_in=1 for 30 cycles → exactly one btn_long pulse, 10 cycles after btn_press. Same stimulus with the macro undefined → btn_long=0 throughout.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer
//   Conditions a raw, bouncy push-button for the LED counter logic. The input
//   is brought into the clk domain through a two-flop synchroniser. A
//   counter-based FSM then accepts a change only after DEBOUNCE_CYCLES
//   unbroken stable cycles. It produces a clean level and one-cycle
//   press/release strobes.
//
//   Optional feature macro: LONG_PRESS_EN
//     When defined, a hold counter produces one btn_long strobe once the
//     button has been held for LONG_CYCLES cycles after the accepted press.
//     When undefined, btn_long is tied to 0.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_in       raw button, active-high, asynchronous to clk
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle strobe on accepted press
//   btn_release  one-cycle strobe on accepted release
//   btn_long     one-cycle strobe on long press (0 without LONG_PRESS_EN)
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK_PRESS,
    PRESSED,
    CHECK_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Both counts must fit the shared counter width without wrapping.
  if (DEBOUNCE_CYCLES < 1 ||
      longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (LONG_CYCLES < 1 ||
      longint'(LONG_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_long
    $error("LONG_CYCLES out of range for CNT_W");
  end

  state_t           state;
  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // ---- stage p0/p1: two-flop synchroniser; only sync_p1 reaches the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: debounce FSM with registered level and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_p1) begin
            state <= CHECK_PRESS;
            cnt   <= '0;
          end
        end
        CHECK_PRESS: begin
          if (!sync_p1) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state     <= PRESSED;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_p1) begin
            state <= CHECK_RELEASE;
            cnt   <= '0;
          end
        end
        CHECK_RELEASE: begin
          if (sync_p1) begin
            state <= PRESSED;
          end else if (cnt == DEB_LAST) begin
            state       <= IDLE;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hold_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v == lim) ? v : v + 1'b1;
  endfunction

  // ---- stage p3: hold counter. It keeps running through a bounce back
  // from CHECK_RELEASE and parks one past LONG_LAST, so each press can
  // produce only one strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (state == PRESSED || state == CHECK_RELEASE) begin
        hold_cnt <= sat_inc(hold_cnt, LONG_SAT);
        if (hold_cnt == LONG_LAST) begin
          btn_long <= 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule
